// File: rtl/xor_parity_rx_if.sv
// Receiver-side bundle for xor_parity_rx: serial input, bit strobe, consumer handshake and status.
// slave = receiver, master = line driver / byte consumer.
interface xor_parity_rx_if;
  logic       sin;
  logic       bit_en;
  logic       data_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport slave (
    input  sin, bit_en, data_ready,
    output data, data_valid, parity_err, frame_err, overrun, busy
  );

  modport master (
    output sin, bit_en, data_ready,
    input  data, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/xor_parity_rx.sv
// Strobed 11-bit frame receiver (start, 8 data LSB first, parity, stop) with a one-deep output slot.
// Define XOR_PARITY_RX_OVERRUN_EN to drop frames that complete while the slot is full and unread.
module xor_parity_rx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  xor_parity_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_acc;
  logic [7:0] r_shift;
  logic       r_perr;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_parity_err;
  logic       r_frame_err;
  logic       r_busy;
  logic       w_drop;

`ifdef XOR_PARITY_RX_OVERRUN_EN
  logic r_overrun;
  assign w_drop      = r_valid & ~bus.data_ready;
  assign bus.overrun = r_overrun;
`else
  assign w_drop      = 1'b0;
  assign bus.overrun = 1'b0;
`endif

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_acc        <= 1'b0;
      r_shift      <= 8'h00;
      r_perr       <= 1'b0;
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef XOR_PARITY_RX_OVERRUN_EN
      r_overrun    <= 1'b0;
`endif
    end else begin
`ifdef XOR_PARITY_RX_OVERRUN_EN
      r_overrun <= 1'b0;
`endif
      // A load later in this block overrides the consume, keeping valid high.
      if (r_valid && bus.data_ready)
        r_valid <= 1'b0;

      if (bus.bit_en) begin
        case (r_state)
          IDLE: begin
            if (!bus.sin) begin
              r_state <= DATA;
              r_cnt   <= 3'd0;
              r_acc   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {bus.sin, r_shift[7:1]};
            r_acc   <= r_acc ^ bus.sin;
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7)
              r_state <= PARITY;
          end
          PARITY: begin
            r_perr  <= r_acc ^ bus.sin ^ PARITY_ODD;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_drop) begin
`ifdef XOR_PARITY_RX_OVERRUN_EN
              r_overrun <= 1'b1;
`endif
            end else begin
              r_data       <= r_shift;
              r_parity_err <= r_perr;
              r_frame_err  <= ~bus.sin;
              r_valid      <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_parity_rx.sv
// Scoreboard bench for xor_parity_rx: directed frames plus randomized frames/backpressure,
// with an even-parity and an odd-parity instance driven by the same line.
module tb_xor_parity_rx;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   ovr_cycles = 0;
  bit   rand_rdy = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t q[$];

`ifdef XOR_PARITY_RX_OVERRUN_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  xor_parity_rx_if ifc();
  xor_parity_rx_if if_odd();

  assign if_odd.sin        = ifc.sin;
  assign if_odd.bit_en     = ifc.bit_en;
  assign if_odd.data_ready = ifc.data_ready;

  xor_parity_rx #(.PARITY_ODD(1'b0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  xor_parity_rx #(.PARITY_ODD(1'b1)) u_odd (.clk(clk), .rst_n(rst_n), .bus(if_odd.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (ifc.overrun === 1'b1)
      ovr_cycles++;
    if (rst_n && ifc.data_valid && ifc.data_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_frame", {24'd0, ifc.data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("frame data=%02h perr=%0b ferr=%0b (expect %02h %0b %0b)",
                 ifc.data, ifc.parity_err, ifc.frame_err, e.d, e.pe, e.fe);
        chk("data", {24'd0, ifc.data}, {24'd0, e.d});
        chk("parity_err", {31'd0, ifc.parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, ifc.frame_err}, {31'd0, e.fe});
        chk("odd_valid", {31'd0, if_odd.data_valid}, 32'd1);
        chk("odd_data", {24'd0, if_odd.data}, {24'd0, e.d});
        chk("odd_parity_err", {31'd0, if_odd.parity_err}, {31'd0, ~e.pe});
      end
    end
  end

  // Random consumer backpressure, only while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy)
      ifc.data_ready = 1'($urandom_range(1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic b);
    ifc.sin    = b;
    ifc.bit_en = 1'b1;
    @(posedge clk);
    #1;
    ifc.bit_en = 1'b0;
    ifc.sin    = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; nbits < 11 sends only the leading part of it.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input int gap, input bit push, input int nbits = 11);
    logic [10:0] bits;
    exp_t e;
    bits = {stopb, pbit, d, 1'b0};
    e.d  = d;
    e.pe = (^d) ^ pbit;
    e.fe = ~stopb;
    for (int i = 0; i < nbits; i++) begin
      if (i == 10 && push)
        q.push_back(e);
      strobe(bits[i]);
      chk("busy", {31'd0, ifc.busy}, (i == 10) ? 32'd0 : 32'd1);
      if (i < 10)
        idle_cycles(gap);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_data", {24'd0, ifc.data}, 32'd0);
    chk("rst_valid", {31'd0, ifc.data_valid}, 32'd0);
    chk("rst_parity_err", {31'd0, ifc.parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, ifc.frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, ifc.overrun}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.sin        = 1'b1;
    ifc.bit_en     = 1'b0;
    ifc.data_ready = 1'b1;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed frames with the consumer always ready.
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    wait_drain();
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b1);
    wait_drain();
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b1);
    wait_drain();
    send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b1);
    wait_drain();

    // Partial frame interrupted by reset, then a clean frame.
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 5);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    send_frame(8'h81, 1'b0, 1'b1, 0, 1'b1);
    wait_drain();

    // Two back-to-back frames with the consumer stalled.
    ifc.data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, DROP_MODE);
    send_frame(8'h22, 1'b1, 1'b0, 0, !DROP_MODE);
    idle_cycles(2);
    chk("stall_valid", {31'd0, ifc.data_valid}, 32'd1);
    chk("stall_data", {24'd0, ifc.data}, DROP_MODE ? 32'h11 : 32'h22);
    chk("stall_frame_err", {31'd0, ifc.frame_err}, DROP_MODE ? 32'd0 : 32'd1);
    chk("overrun_cycles", ovr_cycles, DROP_MODE ? 32'd1 : 32'd0);
    ifc.data_ready = 1'b1;
    wait_drain();

    // Randomized frames, idle strobes and backpressure; one frame in flight at a time.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       pb;
      logic       sb;
      int         gap;
      int         idles;
      d     = 8'($urandom);
      pb    = 1'($urandom_range(1));
      sb    = ($urandom_range(3) != 0);
      gap   = $urandom_range(2);
      idles = $urandom_range(3);
      for (int k = 0; k < idles; k++) begin
        strobe(1'b1);
        chk("idle_busy", {31'd0, ifc.busy}, 32'd0);
      end
      send_frame(d, pb, sb, gap, 1'b1);
      wait_drain();
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    ifc.data_ready = 1'b1;
    wait_drain();
    chk("overrun_total", ovr_cycles, DROP_MODE ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
